id_stage: RTL and testbench
===========================

# id_stage

Decode/issue stage of the RV32IM core. It is the producer side of the ALU interface. It accepts fetched instruction words and decodes them into `alucode`, `op1` and `op2` using the `ALU_*` encodings. It reads the register file, selects operands and holds the result in a registered ID/EX pipeline slot with a valid/ready handshake. It consumes the ALU's `br_taken` back as a flush and computes the redirect target for branches and jumps.

## Interface
Parameters:
- `RESET_PC`, default 32'h0: value of `ex_pc` and `ex_br_target` while in reset.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `if_valid`  in  1  instruction word present
- `if_insn`  in  32  instruction word
- `if_pc`  in  32  instruction address
- `id_ready`  out  1  stage can accept this cycle
- `rs1_addr`, `rs2_addr`  out  5  combinational register file read addresses (`if_insn[19:15]`, `if_insn[24:20]`)
- `rs1_data`, `rs2_data`  in  32  combinational read data; x0 reads as 0
- `flush`  in  1  branch taken in EX; kills the slot and the incoming word
- `ex_ready`  in  1  EX accepts the slot
- `ex_valid`  out  1  slot holds a live instruction
- `ex_alucode`  out  6  ALU operation
- `ex_op1`, `ex_op2`  out  32  ALU operands
- `ex_store_data`  out  32  rs2 value for stores
- `ex_rd`  out  5  destination register
- `ex_reg_we`  out  1  writeback enable; forced to 0 when rd=0
- `ex_br_target`  out  32  redirect address
- `ex_pc`  out  32  pc of the slot
- `ex_illegal`  out  1  undecodable instruction

## Operation
- Accept condition: `if_valid && id_ready && !flush`.
- `id_ready = !ex_valid || ex_ready`.
- Operand selection by opcode:
  - OP: op1=rs1, op2=rs2. Covers ADD…AND, plus MUL/DIV/REM when funct7=0000001.
  - OP-IMM: op1=rs1, op2=sign-extended I-immediate. For shifts, op2=shamt zero-extended; SRAI vs SRLI is chosen by bit 30.
  - LOAD: op1=rs1, op2=I-immediate, alucode `ALU_LB`…`ALU_LHU` from funct3.
  - STORE: op1=rs1, op2=S-immediate, store_data=rs2, reg_we=0.
  - BRANCH: op1=rs1, op2=rs2, `ALU_BEQ`…`ALU_BGEU`, reg_we=0, br_target=pc+B-immediate.
  - JAL: alucode=`ALU_JAL`, op1=0, op2=pc, br_target=pc+J-immediate. The ALU returns op2+4 as the link value.
  - JALR: alucode=`ALU_JALR`, op1=0, op2=pc, br_target=(rs1+I-immediate)&~1.
  - LUI: `ALU_LUI`, op2={imm[31:12],12'b0}.
  - AUIPC: `ALU_ADD`, op1=pc, op2=U-immediate.
  - MISC-MEM and SYSTEM: `ALU_ADD` with zero operands, reg_we=0 (treated as no-op).
- Any other opcode, or an invalid funct3/funct7 combination: ex_illegal=1, reg_we=0, alucode=`ALU_ADD`, op1=op2=0. The instruction still flows as a valid slot.
- br_target is 0 for non-control instructions. All additions wrap modulo 2^32.

## Timing
- Latency: 1 cycle. An instruction accepted at edge N appears on `ex_*` after edge N.
- Reset: `ex_valid`=0, `ex_alucode`=0, `ex_op1`=`ex_op2`=`ex_store_data`=0, `ex_rd`=0, `ex_reg_we`=0, `ex_illegal`=0, `ex_pc`=`ex_br_target`=`RESET_PC`.
- Stall: while `ex_valid && !ex_ready`, every `ex_*` output stays bit-stable and `id_ready`=0.
- Flush has priority over everything else:
  - next cycle `ex_valid`=0;
  - a word offered in the flush cycle is dropped even if `id_ready`=1;
  - data fields may hold stale values but `ex_reg_we` is cleared.
- Flush during a stall still clears `ex_valid`.
- Simultaneous `ex_ready` and accept: the slot is replaced with no bubble (back-to-back throughput of 1 per cycle).
- Reset asserted mid-operation: outputs take their reset values immediately, without waiting for `clk`.

## Structure
- `ALU_*` codes, opcode constants and `ENABLE`/`DISABLE` come from the shared `define.vh`; add `OP_LOAD`, `OP_STORE`, `OP_BRANCH`, `OP_JAL`, `OP_JALR`, `OP_LUI`, `OP_AUIPC`, `OP_OP`, `OP_OPIMM` there if they are absent.
- One combinational sub-module, `imm_gen` (insn → I/S/B/U/J immediates, all sign-extended to 32 bits).
- The decode function and the pipeline register live in `id_stage`.

## Test plan
- Reset with `if_valid`=1 → `ex_valid`=0, all fields at reset values. After reset release, `0x00510093` (addi x1,x2,5) with rs1_data=10 → `rs1_addr`=2; next cycle `ex_alucode`=`ALU_ADD`, op1=10, op2=5, rd=1, reg_we=1.
- `0xFE208CE3` (beq x1,x2,-8) at pc=0x100 with rs1=rs2=7 → `ALU_BEQ`, op1=op2=7, br_target=0xF8, reg_we=0.
- `0x010000EF` (jal x1,16) at pc=0x200 → `ALU_JAL`, op2=0x200, br_target=0x210, rd=1. Then `0x123452B7` (lui x5) → op2=0x12345000.
- Stall: `ex_ready`=0 for 3 cycles with a new word offered → `id_ready`=0, outputs unchanged; on release the new word appears the cycle after release.
- Flush with a word offered → `ex_valid`=0 next cycle, and the offered word never appears. Opcode 0x7F → `ex_illegal`=1, reg_we=0.
- Reset pulse while a slot is stalled → `ex_valid` drops asynchronously, before the next `clk` edge.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared decode constants and bundles for the RV32IM id_stage.
// ALU operation codes, opcode map and the decoded ID/EX payload.
package id_stage_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [5:0] ALU_LUI    = 6'd0;
  localparam logic [5:0] ALU_JAL    = 6'd1;
  localparam logic [5:0] ALU_JALR   = 6'd2;
  localparam logic [5:0] ALU_BEQ    = 6'd3;
  localparam logic [5:0] ALU_BNE    = 6'd4;
  localparam logic [5:0] ALU_BLT    = 6'd5;
  localparam logic [5:0] ALU_BGE    = 6'd6;
  localparam logic [5:0] ALU_BLTU   = 6'd7;
  localparam logic [5:0] ALU_BGEU   = 6'd8;
  localparam logic [5:0] ALU_LB     = 6'd9;
  localparam logic [5:0] ALU_LH     = 6'd10;
  localparam logic [5:0] ALU_LW     = 6'd11;
  localparam logic [5:0] ALU_LBU    = 6'd12;
  localparam logic [5:0] ALU_LHU    = 6'd13;
  localparam logic [5:0] ALU_SB     = 6'd14;
  localparam logic [5:0] ALU_SH     = 6'd15;
  localparam logic [5:0] ALU_SW     = 6'd16;
  localparam logic [5:0] ALU_ADD    = 6'd17;
  localparam logic [5:0] ALU_SUB    = 6'd18;
  localparam logic [5:0] ALU_SLT    = 6'd19;
  localparam logic [5:0] ALU_SLTU   = 6'd20;
  localparam logic [5:0] ALU_XOR    = 6'd21;
  localparam logic [5:0] ALU_OR     = 6'd22;
  localparam logic [5:0] ALU_AND    = 6'd23;
  localparam logic [5:0] ALU_SLL    = 6'd24;
  localparam logic [5:0] ALU_SRL    = 6'd25;
  localparam logic [5:0] ALU_SRA    = 6'd26;
  localparam logic [5:0] ALU_MUL    = 6'd27;
  localparam logic [5:0] ALU_MULH   = 6'd28;
  localparam logic [5:0] ALU_MULHSU = 6'd29;
  localparam logic [5:0] ALU_MULHU  = 6'd30;
  localparam logic [5:0] ALU_DIV    = 6'd31;
  localparam logic [5:0] ALU_DIVU   = 6'd32;
  localparam logic [5:0] ALU_REM    = 6'd33;
  localparam logic [5:0] ALU_REMU   = 6'd34;

  typedef struct packed {
    logic [5:0]  alucode;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] store_data;
    logic [31:0] br_target;
    logic        reg_we;
    logic        illegal;
  } dec_t;

endpackage

// File: rtl/id_stage_imm_gen.sv
// Immediate extraction for all RV32 formats.
// Every output is already sign-extended (U is left-aligned).
module imm_gen (
  input  logic [31:0] i_insn,
  output logic [31:0] o_imm_i,
  output logic [31:0] o_imm_s,
  output logic [31:0] o_imm_b,
  output logic [31:0] o_imm_u,
  output logic [31:0] o_imm_j
);

  assign o_imm_i = {{20{i_insn[31]}},
                    i_insn[31:20]};
  assign o_imm_s = {{20{i_insn[31]}},
                    i_insn[31:25],
                    i_insn[11:7]};
  assign o_imm_b = {{19{i_insn[31]}},
                    i_insn[31],
                    i_insn[7],
                    i_insn[30:25],
                    i_insn[11:8],
                    1'b0};
  assign o_imm_u = {i_insn[31:12], 12'b0};
  assign o_imm_j = {{11{i_insn[31]}},
                    i_insn[31],
                    i_insn[19:12],
                    i_insn[20],
                    i_insn[30:21],
                    1'b0};

endmodule

// File: rtl/id_stage.sv
// RV32IM decode/issue stage: decodes, reads operands and
// holds one registered ID/EX slot behind a valid/ready handshake.
module id_stage
  import id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_insn,
  input  logic [31:0] if_pc,
  output logic        id_ready,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [5:0]  ex_alucode,
  output logic [31:0] ex_op1,
  output logic [31:0] ex_op2,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_we,
  output logic [31:0] ex_br_target,
  output logic [31:0] ex_pc,
  output logic        ex_illegal
);

  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_shamt;
  logic        w_bad;
  logic        w_accept;
  dec_t        w_dec;

  logic        r_valid;
  dec_t        r_dec;
  logic [4:0]  r_rd;
  logic [31:0] r_pc;

  imm_gen u_imm (
    .i_insn  (if_insn),
    .o_imm_i (w_imm_i),
    .o_imm_s (w_imm_s),
    .o_imm_b (w_imm_b),
    .o_imm_u (w_imm_u),
    .o_imm_j (w_imm_j)
  );

  assign w_opc    = if_insn[6:0];
  assign w_f3     = if_insn[14:12];
  assign w_f7     = if_insn[31:25];
  assign w_shamt  = {27'b0, if_insn[24:20]};
  assign rs1_addr = if_insn[19:15];
  assign rs2_addr = if_insn[24:20];
  assign id_ready = !r_valid || ex_ready;
  // flush is handled by priority in the slot register
  assign w_accept = if_valid && id_ready;

  // Decode the offered word into ALU code and operands.
  always_comb begin
    w_bad            = 1'b0;
    w_dec            = '0;
    w_dec.alucode    = ALU_ADD;
    w_dec.reg_we     = ENABLE;
    unique case (w_opc)
      OP_OP: begin
        w_dec.op1 = rs1_data;
        w_dec.op2 = rs2_data;
        unique case (1'b1)
          (w_f7 == 7'b0000000): begin
            case (w_f3)
              3'd0:    w_dec.alucode = ALU_ADD;
              3'd1:    w_dec.alucode = ALU_SLL;
              3'd2:    w_dec.alucode = ALU_SLT;
              3'd3:    w_dec.alucode = ALU_SLTU;
              3'd4:    w_dec.alucode = ALU_XOR;
              3'd5:    w_dec.alucode = ALU_SRL;
              3'd6:    w_dec.alucode = ALU_OR;
              default: w_dec.alucode = ALU_AND;
            endcase
          end
          (w_f7 == 7'b0100000): begin
            case (w_f3)
              3'd0:    w_dec.alucode = ALU_SUB;
              3'd5:    w_dec.alucode = ALU_SRA;
              default: w_bad = 1'b1;
            endcase
          end
          (w_f7 == 7'b0000001): begin
            case (w_f3)
              3'd0:    w_dec.alucode = ALU_MUL;
              3'd1:    w_dec.alucode = ALU_MULH;
              3'd2:    w_dec.alucode = ALU_MULHSU;
              3'd3:    w_dec.alucode = ALU_MULHU;
              3'd4:    w_dec.alucode = ALU_DIV;
              3'd5:    w_dec.alucode = ALU_DIVU;
              3'd6:    w_dec.alucode = ALU_REM;
              default: w_dec.alucode = ALU_REMU;
            endcase
          end
          default: w_bad = 1'b1;
        endcase
      end
      OP_OPIMM: begin
        w_dec.op1 = rs1_data;
        w_dec.op2 = w_imm_i;
        case (w_f3)
          3'd0: w_dec.alucode = ALU_ADD;
          3'd2: w_dec.alucode = ALU_SLT;
          3'd3: w_dec.alucode = ALU_SLTU;
          3'd4: w_dec.alucode = ALU_XOR;
          3'd6: w_dec.alucode = ALU_OR;
          3'd7: w_dec.alucode = ALU_AND;
          3'd1: begin
            w_dec.op2     = w_shamt;
            w_dec.alucode = ALU_SLL;
            w_bad         = (w_f7 != 7'b0000000);
          end
          default: begin
            w_dec.op2     = w_shamt;
            w_dec.alucode = if_insn[30] ? ALU_SRA
                                        : ALU_SRL;
            w_bad         = ({w_f7[6], w_f7[4:0]}
                             != 6'b0);
          end
        endcase
      end
      OP_LOAD: begin
        w_dec.op1 = rs1_data;
        w_dec.op2 = w_imm_i;
        case (w_f3)
          3'd0:    w_dec.alucode = ALU_LB;
          3'd1:    w_dec.alucode = ALU_LH;
          3'd2:    w_dec.alucode = ALU_LW;
          3'd4:    w_dec.alucode = ALU_LBU;
          3'd5:    w_dec.alucode = ALU_LHU;
          default: w_bad = 1'b1;
        endcase
      end
      OP_STORE: begin
        w_dec.op1        = rs1_data;
        w_dec.op2        = w_imm_s;
        w_dec.store_data = rs2_data;
        w_dec.reg_we     = DISABLE;
        case (w_f3)
          3'd0:    w_dec.alucode = ALU_SB;
          3'd1:    w_dec.alucode = ALU_SH;
          3'd2:    w_dec.alucode = ALU_SW;
          default: w_bad = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        w_dec.op1       = rs1_data;
        w_dec.op2       = rs2_data;
        w_dec.reg_we    = DISABLE;
        w_dec.br_target = if_pc + w_imm_b;
        case (w_f3)
          3'd0:    w_dec.alucode = ALU_BEQ;
          3'd1:    w_dec.alucode = ALU_BNE;
          3'd4:    w_dec.alucode = ALU_BLT;
          3'd5:    w_dec.alucode = ALU_BGE;
          3'd6:    w_dec.alucode = ALU_BLTU;
          3'd7:    w_dec.alucode = ALU_BGEU;
          default: w_bad = 1'b1;
        endcase
      end
      OP_JAL: begin
        w_dec.alucode   = ALU_JAL;
        w_dec.op2       = if_pc;
        w_dec.br_target = if_pc + w_imm_j;
      end
      OP_JALR: begin
        w_dec.alucode   = ALU_JALR;
        w_dec.op2       = if_pc;
        w_dec.br_target = (rs1_data + w_imm_i)
                          & ~32'd1;
        w_bad           = (w_f3 != 3'd0);
      end
      OP_LUI: begin
        w_dec.alucode = ALU_LUI;
        w_dec.op2     = w_imm_u;
      end
      OP_AUIPC: begin
        w_dec.op1 = if_pc;
        w_dec.op2 = w_imm_u;
      end
      OP_MISC, OP_SYSTEM: begin
        w_dec.reg_we = DISABLE;
      end
      default: w_bad = 1'b1;
    endcase
    if (w_bad) begin
      w_dec         = '0;
      w_dec.alucode = ALU_ADD;
      w_dec.illegal = ENABLE;
    end
    if (if_insn[11:7] == 5'd0) begin
      w_dec.reg_we = DISABLE;
    end
  end

  // ID/EX slot: flush wins, then load, then drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid           <= 1'b0;
      r_dec             <= '0;
      r_dec.br_target   <= RESET_PC;
      r_rd              <= 5'd0;
      r_pc              <= RESET_PC;
    end else if (flush) begin
      r_valid           <= 1'b0;
      r_dec.reg_we      <= DISABLE;
    end else if (w_accept) begin
      r_valid           <= 1'b1;
      r_dec             <= w_dec;
      r_rd              <= if_insn[11:7];
      r_pc              <= if_pc;
    end else if (ex_ready) begin
      r_valid           <= 1'b0;
    end
  end

  assign ex_valid      = r_valid;
  assign ex_alucode    = r_dec.alucode;
  assign ex_op1        = r_dec.op1;
  assign ex_op2        = r_dec.op2;
  assign ex_store_data = r_dec.store_data;
  assign ex_rd         = r_rd;
  assign ex_reg_we     = r_dec.reg_we;
  assign ex_br_target  = r_dec.br_target;
  assign ex_pc         = r_pc;
  assign ex_illegal    = r_dec.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus
// random instruction streams against a mnemonic-level model.
module tb_id_stage;
  import id_stage_pkg::*;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_insn;
  logic [31:0] if_pc;
  logic        id_ready;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [5:0]  ex_alucode;
  logic [31:0] ex_op1;
  logic [31:0] ex_op2;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_we;
  logic [31:0] ex_br_target;
  logic [31:0] ex_pc;
  logic        ex_illegal;

  int checks = 0;
  int errors = 0;

  logic [31:0] regs [32];

  id_stage #(.RESET_PC(RPC)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_valid      (if_valid),
    .if_insn       (if_insn),
    .if_pc         (if_pc),
    .id_ready      (id_ready),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .flush         (flush),
    .ex_ready      (ex_ready),
    .ex_valid      (ex_valid),
    .ex_alucode    (ex_alucode),
    .ex_op1        (ex_op1),
    .ex_op2        (ex_op2),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .ex_reg_we     (ex_reg_we),
    .ex_br_target  (ex_br_target),
    .ex_pc         (ex_pc),
    .ex_illegal    (ex_illegal)
  );

  always #5 clk = ~clk;

  always_comb begin
    rs1_data = regs[rs1_addr];
    rs2_data = regs[rs2_addr];
  end

  typedef enum int {
    K_ADDI, K_SLTI, K_XORI, K_SLLI, K_SRLI, K_SRAI,
    K_ADD, K_SUB, K_MUL, K_DIVU, K_LW, K_LBU,
    K_SW, K_SB, K_BEQ, K_BLTU, K_JAL, K_JALR,
    K_LUI, K_AUIPC, K_FENCE, K_BAD
  } kind_t;
  localparam int NK = 22;

  typedef struct {
    logic [5:0]  alu;
    logic [31:0] op1, op2, sd, tgt, pc;
    logic [4:0]  rd;
    logic        we, ill, wr;
  } exp_t;

  function automatic logic [31:0] enc(
    kind_t k, logic [4:0] rd, logic [4:0] rs1,
    logic [4:0] rs2, int imm);
    logic [31:0] v;
    v = imm;
    case (k)
      K_ADDI:  return {v[11:0], rs1, 3'd0, rd, 7'h13};
      K_SLTI:  return {v[11:0], rs1, 3'd2, rd, 7'h13};
      K_XORI:  return {v[11:0], rs1, 3'd4, rd, 7'h13};
      K_SLLI:  return {7'h00, v[4:0], rs1, 3'd1, rd, 7'h13};
      K_SRLI:  return {7'h00, v[4:0], rs1, 3'd5, rd, 7'h13};
      K_SRAI:  return {7'h20, v[4:0], rs1, 3'd5, rd, 7'h13};
      K_ADD:   return {7'h00, rs2, rs1, 3'd0, rd, 7'h33};
      K_SUB:   return {7'h20, rs2, rs1, 3'd0, rd, 7'h33};
      K_MUL:   return {7'h01, rs2, rs1, 3'd0, rd, 7'h33};
      K_DIVU:  return {7'h01, rs2, rs1, 3'd5, rd, 7'h33};
      K_LW:    return {v[11:0], rs1, 3'd2, rd, 7'h03};
      K_LBU:   return {v[11:0], rs1, 3'd4, rd, 7'h03};
      K_SW:    return {v[11:5], rs2, rs1, 3'd2, v[4:0], 7'h23};
      K_SB:    return {v[11:5], rs2, rs1, 3'd0, v[4:0], 7'h23};
      K_BEQ:   return {v[12], v[10:5], rs2, rs1, 3'd0,
                       v[4:1], v[11], 7'h63};
      K_BLTU:  return {v[12], v[10:5], rs2, rs1, 3'd6,
                       v[4:1], v[11], 7'h63};
      K_JAL:   return {v[20], v[10:1], v[11], v[19:12],
                       rd, 7'h6F};
      K_JALR:  return {v[11:0], rs1, 3'd0, rd, 7'h67};
      K_LUI:   return {v[31:12], rd, 7'h37};
      K_AUIPC: return {v[31:12], rd, 7'h17};
      K_FENCE: return 32'h0FF0000F;
      default: return {v[24:0], 7'h7F};
    endcase
  endfunction

  function automatic int pick_imm(kind_t k);
    case (k)
      K_SLLI, K_SRLI, K_SRAI:
        return int'($urandom_range(0, 31));
      K_BEQ, K_BLTU:
        return (int'($urandom_range(0, 4095)) - 2048) * 2;
      K_JAL:
        return (int'($urandom_range(0, 1048575))
                - 524288) * 2;
      K_LUI, K_AUIPC, K_BAD:
        return int'($urandom & 32'hFFFF_F000);
      default:
        return int'($urandom_range(0, 4095)) - 2048;
    endcase
  endfunction

  // Expected slot contents straight from instruction semantics.
  function automatic exp_t model(
    kind_t k, logic [4:0] rd, logic [4:0] rs1,
    logic [4:0] rs2, int imm, logic [31:0] pc);
    exp_t e;
    logic [31:0] v1, v2, iv;
    v1 = regs[rs1];
    v2 = regs[rs2];
    iv = imm;
    e = '{alu: ALU_ADD, op1: 0, op2: 0, sd: 0, tgt: 0,
          pc: pc, rd: rd, we: 1, ill: 0, wr: 1};
    case (k)
      K_ADDI: begin e.op1 = v1; e.op2 = iv; end
      K_SLTI: begin e.alu = ALU_SLT; e.op1 = v1; e.op2 = iv; end
      K_XORI: begin e.alu = ALU_XOR; e.op1 = v1; e.op2 = iv; end
      K_SLLI: begin e.alu = ALU_SLL; e.op1 = v1; e.op2 = iv; end
      K_SRLI: begin e.alu = ALU_SRL; e.op1 = v1; e.op2 = iv; end
      K_SRAI: begin e.alu = ALU_SRA; e.op1 = v1; e.op2 = iv; end
      K_ADD:  begin e.op1 = v1; e.op2 = v2; end
      K_SUB:  begin e.alu = ALU_SUB; e.op1 = v1; e.op2 = v2; end
      K_MUL:  begin e.alu = ALU_MUL; e.op1 = v1; e.op2 = v2; end
      K_DIVU: begin e.alu = ALU_DIVU; e.op1 = v1; e.op2 = v2; end
      K_LW:   begin e.alu = ALU_LW; e.op1 = v1; e.op2 = iv; end
      K_LBU:  begin e.alu = ALU_LBU; e.op1 = v1; e.op2 = iv; end
      K_SW, K_SB: begin
        e.alu = (k == K_SW) ? ALU_SW : ALU_SB;
        e.op1 = v1; e.op2 = iv; e.sd = v2;
        e.we = 0; e.wr = 0;
      end
      K_BEQ, K_BLTU: begin
        e.alu = (k == K_BEQ) ? ALU_BEQ : ALU_BLTU;
        e.op1 = v1; e.op2 = v2; e.tgt = pc + iv;
        e.we = 0; e.wr = 0;
      end
      K_JAL: begin
        e.alu = ALU_JAL; e.op2 = pc; e.tgt = pc + iv;
      end
      K_JALR: begin
        e.alu = ALU_JALR; e.op2 = pc;
        e.tgt = (v1 + iv) & 32'hFFFF_FFFE;
      end
      K_LUI:   begin e.alu = ALU_LUI; e.op2 = iv; end
      K_AUIPC: begin e.op1 = pc; e.op2 = iv; end
      K_FENCE: begin e.we = 0; e.wr = 0; end
      default: begin e.ill = 1; e.we = 0; e.wr = 0; end
    endcase
    if (rd == 5'd0) e.we = 0;
    return e;
  endfunction

  task automatic test_reset();
    rst = 1; if_valid = 1; if_insn = 32'h00510093;
    if_pc = 32'h40; flush = 0; ex_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ex_valid !== 1'b0 || ex_reg_we !== 1'b0 ||
        ex_illegal !== 1'b0 || ex_rd !== 5'd0) begin
      errors++;
      $display("FAIL reset_ctl v=%b we=%b ill=%b rd=%0d want 0",
               ex_valid, ex_reg_we, ex_illegal, ex_rd);
    end
    checks++;
    if (ex_alucode !== 6'd0 || ex_op1 !== 0 ||
        ex_op2 !== 0 || ex_store_data !== 0) begin
      errors++;
      $display("FAIL reset_data alu=%0d op1=%h op2=%h sd=%h want 0",
               ex_alucode, ex_op1, ex_op2, ex_store_data);
    end
    checks++;
    if (ex_pc !== RPC || ex_br_target !== RPC) begin
      errors++;
      $display("FAIL reset_pc pc=%h tgt=%h want %h",
               ex_pc, ex_br_target, RPC);
    end
    rst = 0; if_valid = 0;
  endtask

  task automatic test_addi();
    regs[2] = 32'd10;
    if_insn = 32'h00510093; if_pc = 32'h0; if_valid = 1;
    #1;
    checks++;
    if (rs1_addr !== 5'd2) begin
      errors++;
      $display("FAIL addi_rs1addr got %0d want 2", rs1_addr);
    end
    @(posedge clk); #1;
    checks++;
    if (ex_valid !== 1 || ex_alucode !== ALU_ADD ||
        ex_op1 !== 32'd10 || ex_op2 !== 32'd5 ||
        ex_rd !== 5'd1 || ex_reg_we !== 1) begin
      errors++;
      $display("FAIL addi v=%b alu=%0d op1=%0d op2=%0d rd=%0d we=%b want 1 %0d 10 5 1 1",
               ex_valid, ex_alucode, ex_op1, ex_op2,
               ex_rd, ex_reg_we, ALU_ADD);
    end
  endtask

  task automatic test_beq();
    regs[1] = 32'd7; regs[2] = 32'd7;
    if_insn = 32'hFE208CE3; if_pc = 32'h100;
    @(posedge clk); #1;
    checks++;
    if (ex_alucode !== ALU_BEQ || ex_op1 !== 32'd7 ||
        ex_op2 !== 32'd7 || ex_br_target !== 32'hF8 ||
        ex_reg_we !== 0) begin
      errors++;
      $display("FAIL beq alu=%0d op1=%0d op2=%0d tgt=%h we=%b want %0d 7 7 f8 0",
               ex_alucode, ex_op1, ex_op2, ex_br_target,
               ex_reg_we, ALU_BEQ);
    end
  endtask

  task automatic test_back_to_back();
    if_insn = 32'h010000EF; if_pc = 32'h200;
    @(posedge clk); #1;
    checks++;
    if (ex_alucode !== ALU_JAL || ex_op1 !== 0 ||
        ex_op2 !== 32'h200 || ex_br_target !== 32'h210 ||
        ex_rd !== 5'd1 || ex_reg_we !== 1) begin
      errors++;
      $display("FAIL jal alu=%0d op1=%h op2=%h tgt=%h rd=%0d want %0d 0 200 210 1",
               ex_alucode, ex_op1, ex_op2, ex_br_target,
               ex_rd, ALU_JAL);
    end
    if_insn = 32'h123452B7; if_pc = 32'h204;
    @(posedge clk); #1;
    checks++;
    if (ex_valid !== 1 || ex_alucode !== ALU_LUI ||
        ex_op2 !== 32'h12345000 || ex_rd !== 5'd5 ||
        ex_br_target !== 0) begin
      errors++;
      $display("FAIL lui v=%b alu=%0d op2=%h rd=%0d tgt=%h want 1 %0d 12345000 5 0",
               ex_valid, ex_alucode, ex_op2, ex_rd,
               ex_br_target, ALU_LUI);
    end
  endtask

  task automatic test_stall();
    if_insn = enc(K_ADDI, 5'd3, 5'd0, 5'd0, 32'h55);
    if_pc = 32'h300; ex_ready = 1;
    @(posedge clk); #1;
    ex_ready = 0;
    if_insn = enc(K_ADDI, 5'd4, 5'd0, 5'd0, 32'h66);
    if_pc = 32'h304;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (id_ready !== 0) begin
        errors++;
        $display("FAIL stall_ready got %b want 0", id_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (ex_valid !== 1 || ex_op2 !== 32'h55 ||
          ex_rd !== 5'd3 || ex_pc !== 32'h300) begin
        errors++;
        $display("FAIL stall_hold v=%b op2=%h rd=%0d pc=%h want 1 55 3 300",
                 ex_valid, ex_op2, ex_rd, ex_pc);
      end
    end
    ex_ready = 1;
    @(posedge clk); #1;
    checks++;
    if (ex_valid !== 1 || ex_op2 !== 32'h66 ||
        ex_rd !== 5'd4 || ex_pc !== 32'h304) begin
      errors++;
      $display("FAIL stall_release v=%b op2=%h rd=%0d pc=%h want 1 66 4 304",
               ex_valid, ex_op2, ex_rd, ex_pc);
    end
  endtask

  task automatic test_flush();
    flush = 1;
    if_insn = enc(K_ADDI, 5'd5, 5'd0, 5'd0, 32'h77);
    if_pc = 32'h400;
    @(posedge clk); #1;
    checks++;
    if (ex_valid !== 0 || ex_reg_we !== 0) begin
      errors++;
      $display("FAIL flush v=%b we=%b want 0 0",
               ex_valid, ex_reg_we);
    end
    flush = 0; if_valid = 0;
    @(posedge clk); #1;
    checks++;
    if (ex_valid !== 0) begin
      errors++;
      $display("FAIL flush_drop v=%b want 0", ex_valid);
    end
    if_valid = 1; ex_ready = 0;
    @(posedge clk); #1;
    flush = 1;
    @(posedge clk); #1;
    checks++;
    if (ex_valid !== 0) begin
      errors++;
      $display("FAIL flush_stall v=%b want 0", ex_valid);
    end
    flush = 0; ex_ready = 1;
  endtask

  task automatic test_illegal();
    if_valid = 1; if_insn = 32'h0000_00FF;
    if_pc = 32'h500;
    @(posedge clk); #1;
    checks++;
    if (ex_valid !== 1 || ex_illegal !== 1 ||
        ex_reg_we !== 0 || ex_alucode !== ALU_ADD ||
        ex_op1 !== 0 || ex_op2 !== 0) begin
      errors++;
      $display("FAIL illegal v=%b ill=%b we=%b alu=%0d op1=%h op2=%h want 1 1 0 %0d 0 0",
               ex_valid, ex_illegal, ex_reg_we,
               ex_alucode, ex_op1, ex_op2, ALU_ADD);
    end
  endtask

  task automatic test_random();
    exp_t  m, pend;
    logic  m_valid, acc;
    kind_t k;
    logic [4:0]  rd, r1, r2;
    logic [31:0] pc;
    int imm;
    m = '{default: 0};
    flush = 1; if_valid = 0;
    @(posedge clk); #1;
    flush = 0;
    m_valid = 0;
    for (int c = 0; c < 600; c++) begin
      k   = kind_t'($urandom_range(0, NK - 1));
      rd  = 5'($urandom); r1 = 5'($urandom);
      r2  = 5'($urandom);
      imm = pick_imm(k);
      pc  = $urandom & 32'hFFFF_FFFC;
      if_insn  = enc(k, rd, r1, r2, imm);
      if_pc    = pc;
      if_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 9) == 0);
      pend = model(k, rd, r1, r2, imm, pc);
      #1;
      checks++;
      if (id_ready !== (!m_valid || ex_ready)) begin
        errors++;
        $display("FAIL rnd_ready c=%0d got %b want %b",
                 c, id_ready, !m_valid || ex_ready);
      end
      acc = if_valid && (!m_valid || ex_ready) && !flush;
      @(posedge clk); #1;
      if (flush) begin
        m_valid = 0; m.we = 0;
      end else if (acc) begin
        m_valid = 1; m = pend;
      end else if (ex_ready) begin
        m_valid = 0;
      end
      checks++;
      if (ex_valid !== m_valid) begin
        errors++;
        $display("FAIL rnd_valid c=%0d got %b want %b",
                 c, ex_valid, m_valid);
      end
      if (m_valid || flush) begin
        checks++;
        if (ex_reg_we !== m.we) begin
          errors++;
          $display("FAIL rnd_we c=%0d got %b want %b",
                   c, ex_reg_we, m.we);
        end
      end
      if (m_valid) begin
        checks++;
        if (ex_alucode !== m.alu || ex_illegal !== m.ill) begin
          errors++;
          $display("FAIL rnd_alu c=%0d alu=%0d ill=%b want %0d %b",
                   c, ex_alucode, ex_illegal, m.alu, m.ill);
        end
        checks++;
        if (ex_op1 !== m.op1 || ex_op2 !== m.op2) begin
          errors++;
          $display("FAIL rnd_ops c=%0d op1=%h op2=%h want %h %h",
                   c, ex_op1, ex_op2, m.op1, m.op2);
        end
        checks++;
        if (ex_br_target !== m.tgt || ex_pc !== m.pc ||
            ex_store_data !== m.sd) begin
          errors++;
          $display("FAIL rnd_tgt c=%0d tgt=%h pc=%h sd=%h want %h %h %h",
                   c, ex_br_target, ex_pc, ex_store_data,
                   m.tgt, m.pc, m.sd);
        end
        if (m.wr) begin
          checks++;
          if (ex_rd !== m.rd) begin
            errors++;
            $display("FAIL rnd_rd c=%0d got %0d want %0d",
                     c, ex_rd, m.rd);
          end
        end
      end
    end
    flush = 0;
  endtask

  task automatic test_async_reset();
    if_valid = 1; ex_ready = 1;
    if_insn = enc(K_ADDI, 5'd6, 5'd0, 5'd0, 32'h11);
    if_pc = 32'h600;
    @(posedge clk); #1;
    ex_ready = 0; if_valid = 0;
    checks++;
    if (ex_valid !== 1) begin
      errors++;
      $display("FAIL areset_pre v=%b want 1", ex_valid);
    end
    #2 rst = 1;
    #1;
    checks++;
    if (ex_valid !== 0 || ex_pc !== RPC ||
        ex_op2 !== 0 || ex_rd !== 0) begin
      errors++;
      $display("FAIL areset v=%b pc=%h op2=%h rd=%0d want 0 %h 0 0",
               ex_valid, ex_pc, ex_op2, ex_rd, RPC);
    end
    #2 rst = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'd0;
    test_reset();
    test_addi();
    test_beq();
    test_back_to_back();
    test_stall();
    test_flush();
    test_illegal();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
